// File: rtl/bth_mac_acc.sv
// Saturating dot-product accumulator fed by the Booth multiplier's product stream.
// Collects `len` signed products per block and offers the sum on a valid/ready port.
module bth_mac_acc #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*WIDTH-1:0]     prod,
    input  logic                   prod_valid,
    input  logic [CNT_WIDTH-1:0]   len,
    input  logic                   acc_clr,
    output logic [ACC_WIDTH-1:0]   res,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_ovf,
    output logic                   busy,
    output logic                   drop
);

    localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   len_q, len_d;
    logic                   ovf_q, ovf_d;
    logic                   drop_q, drop_d;
    logic                   res_valid_q;
    logic                   busy_q;

    logic [ACC_WIDTH-1:0]   prod_ext;
    logic [SUM_WIDTH-1:0]   sum;
    logic                   sum_ovf;
    logic [ACC_WIDTH-1:0]   sum_sat;
    logic [CNT_WIDTH-1:0]   len_eff;
    logic [CNT_WIDTH-1:0]   cnt_inc;

    // Sign-extended product, widened sum and its clamped value.
    always_comb begin
        prod_ext = ACC_WIDTH'($signed(prod));
        sum      = SUM_WIDTH'($signed(acc_q)) + SUM_WIDTH'($signed(prod_ext));
        sum_ovf  = (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]);
        if (!sum_ovf) begin
            sum_sat = sum[ACC_WIDTH-1:0];
        end else if (sum[ACC_WIDTH]) begin
            sum_sat = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        end else begin
            sum_sat = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        len_eff = (len == '0) ? CNT_WIDTH'(1) : len;
        cnt_inc = cnt_q + CNT_WIDTH'(1);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        drop_d  = 1'b0;

        if (acc_clr) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (prod_valid) begin
                        len_d   = len_eff;
                        acc_d   = prod_ext;
                        cnt_d   = CNT_WIDTH'(1);
                        ovf_d   = 1'b0;
                        state_d = (len_eff == CNT_WIDTH'(1)) ? S_HOLD : S_ACC;
                    end
                end
                S_ACC: begin
                    if (prod_valid) begin
                        acc_d = sum_sat;
                        ovf_d = ovf_q | sum_ovf;
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        if (prod_valid) begin
                            // Back-to-back: consume the result and open the next block.
                            len_d   = len_eff;
                            acc_d   = prod_ext;
                            cnt_d   = CNT_WIDTH'(1);
                            ovf_d   = 1'b0;
                            state_d = (len_eff == CNT_WIDTH'(1)) ? S_HOLD : S_ACC;
                        end else begin
                            state_d = S_IDLE;
                            acc_d   = '0;
                            ovf_d   = 1'b0;
                        end
                    end else if (prod_valid) begin
                        drop_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
            res_valid_q <= (state_d == S_HOLD);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign res       = acc_q;
    assign res_valid = res_valid_q;
    assign res_ovf   = ovf_q;
    assign busy      = busy_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_bth_mac_acc.sv
// Directed scoreboard bench for bth_mac_acc: a 16-bit and an 8-bit accumulator
// instance share one stimulus stream; expected block results are queued when the last term is driven.
module tb_bth_mac_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] prod;
    logic       prod_valid;
    logic [7:0] len;
    logic       acc_clr;
    logic       res_ready;

    logic [15:0] res16;
    logic        res_valid16, res_ovf16, busy16, drop16;
    logic [7:0]  res8;
    logic        res_valid8, res_ovf8, busy8, drop8;

    typedef struct {
        logic [15:0] r16;
        logic        ovf16;
        logic [7:0]  r8;
        logic        ovf8;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bth_mac_acc #(.WIDTH(4), .ACC_WIDTH(16), .CNT_WIDTH(8)) u16 (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid), .len(len),
        .acc_clr(acc_clr), .res(res16), .res_valid(res_valid16), .res_ready(res_ready),
        .res_ovf(res_ovf16), .busy(busy16), .drop(drop16)
    );

    bth_mac_acc #(.WIDTH(4), .ACC_WIDTH(8), .CNT_WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid), .len(len),
        .acc_clr(acc_clr), .res(res8), .res_valid(res_valid8), .res_ready(res_ready),
        .res_ovf(res_ovf8), .busy(busy8), .drop(drop8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [15:0] r16, input logic o16, input logic [7:0] r8, input logic o8);
        exp_t e;
        e.r16 = r16; e.ovf16 = o16; e.r8 = r8; e.ovf8 = o8;
        exp_q.push_back(e);
    endtask

    // Result must be presented on the edge after the final term.
    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, "_valid16"}, 32'(res_valid16), 32'd1);
        check({tag, "_valid8"},  32'(res_valid8),  32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_res16"}, 32'(res16),     32'(e.r16));
            check({tag, "_ovf16"}, 32'(res_ovf16), 32'(e.ovf16));
            check({tag, "_res8"},  32'(res8),      32'(e.r8));
            check({tag, "_ovf8"},  32'(res_ovf8),  32'(e.ovf8));
        end
    endtask

    task automatic term(input logic [7:0] p);
        prod = p;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; prod = '0; prod_valid = 1'b0; len = '0; acc_clr = 1'b0; res_ready = 1'b0;

        // Reset with random product traffic.
        for (int i = 0; i < 2; i++) begin
            prod = 8'($urandom);
            prod_valid = 1'($urandom);
            tick();
        end
        check("rst_res16",   32'(res16),       32'd0);
        check("rst_valid16", 32'(res_valid16), 32'd0);
        check("rst_busy16",  32'(busy16),      32'd0);
        check("rst_ovf16",   32'(res_ovf16),   32'd0);
        check("rst_drop16",  32'(drop16),      32'd0);
        check("rst_res8",    32'(res8),        32'd0);
        rst = 1'b0; prod_valid = 1'b0;
        tick();
        check("idle_busy16", 32'(busy16), 32'd0);

        // Three-term block: 6 - 10 + 20 = 16.
        len = 8'd3;
        term(8'h06);
        check("t1_busy", 32'(busy16), 32'd1);
        check("t1_nvalid", 32'(res_valid16), 32'd0);
        term(8'hF6);
        push(16'h0010, 1'b0, 8'h10, 1'b0);
        term(8'h14);
        pop_check("t1");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_stable_res", 32'(res16), 32'h0010);
            check("t1_stable_valid", 32'(res_valid16), 32'd1);
        end
        consume();
        check("t1_done_valid", 32'(res_valid16), 32'd0);
        check("t1_done_busy",  32'(busy16),      32'd0);
        check("t1_done_res",   32'(res16),       32'd0);

        // len of zero behaves as a single term.
        len = 8'd0;
        push(16'hFFC8, 1'b0, 8'hC8, 1'b0);
        term(8'hC8);
        pop_check("len0");
        consume();

        // Saturation in the 8-bit instance: 64, 127 (clamped), 119, 111.
        len = 8'd4;
        term(8'h40);
        term(8'h40);
        check("sat_mid_res8", 32'(res8),     32'h7F);
        check("sat_mid_ovf8", 32'(res_ovf8), 32'd1);
        check("sat_mid_res16", 32'(res16),   32'h0080);
        term(8'hF8);
        push(16'h0070, 1'b0, 8'h6F, 1'b1);
        term(8'hF8);
        pop_check("sat");
        consume();

        // Fresh block after an overflowed one starts with the flag clear.
        len = 8'd1;
        push(16'h0005, 1'b0, 8'h05, 1'b0);
        term(8'h05);
        pop_check("post_sat");

        // Product while holding an unaccepted result is dropped.
        term(8'h05);
        check("drop_pulse", 32'(drop16), 32'd1);
        check("drop_res",   32'(res16),  32'h0005);
        check("drop_valid", 32'(res_valid16), 32'd1);
        tick();
        check("drop_clear", 32'(drop16), 32'd0);

        // Consume and start a new block on the same edge.
        len = 8'd1;
        res_ready = 1'b1;
        push(16'h0005, 1'b0, 8'h05, 1'b0);
        term(8'h05);
        res_ready = 1'b0;
        pop_check("b2b");
        check("b2b_nodrop", 32'(drop16), 32'd0);
        consume();
        check("b2b_done_valid", 32'(res_valid16), 32'd0);

        // Abort mid-block; a simultaneous product is ignored silently.
        len = 8'd3;
        term(8'h03);
        term(8'h04);
        acc_clr = 1'b1;
        term(8'h09);
        acc_clr = 1'b0;
        check("clr_busy",  32'(busy16),      32'd0);
        check("clr_res",   32'(res16),       32'd0);
        check("clr_drop",  32'(drop16),      32'd0);
        check("clr_valid", 32'(res_valid16), 32'd0);

        // len changes after the first term do not affect the block.
        len = 8'd2;
        term(8'h03);
        len = 8'd9;
        push(16'h0007, 1'b0, 8'h07, 1'b0);
        term(8'h04);
        pop_check("after_clr");
        consume();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bth_mac_acc.md
Name: bth_mac_acc

Overview:
- Downstream consumer of the Booth multiplier: accepts signed products one at a time, accumulates them into a wider saturating signed accumulator, and presents the finished sum on a valid/ready result port.
- Each accumulation block is a dot product of `len` terms.
- Sits between the multiplier's `prod` output and whatever consumes the dot-product results.

Parameters:
- WIDTH, 4, multiplier operand width; product input is 2*WIDTH bits, two's complement.
- ACC_WIDTH, 16, accumulator/result width; must be >= 2*WIDTH.
- CNT_WIDTH, 8, width of the term-count input and internal term counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- prod  input  2*WIDTH  signed product from the multiplier.
- prod_valid  input  1  one-cycle strobe: `prod` holds a finished product this cycle.
- len  input  CNT_WIDTH  number of terms in a block; sampled only when the first term of a block is accepted.
- acc_clr  input  1  abort: discard the current block and any pending result.
- res  output  ACC_WIDTH  accumulated signed result (the accumulator register).
- res_valid  output  1  result available; held until res_ready.
- res_ready  input  1  consumer accepts the result when res_valid && res_ready.
- res_ovf  output  1  sticky saturation flag for the current block/result.
- busy  output  1  high in ACC or HOLD.
- drop  output  1  one-cycle pulse: a product arrived in HOLD and was discarded.

Behaviour:
- Reset (rst=1 at edge): state=IDLE; acc, cnt, len_q=0; res_valid, res_ovf, drop=0. Reset has highest priority and takes effect mid-block.
- FSM has three states: IDLE, ACC, HOLD. Outputs are registered. busy = (state != IDLE). res_valid = (state == HOLD).
- IDLE, prod_valid=1:
  - latch len_q = (len==0) ? 1 : len;
  - acc = sign-extend(prod) to ACC_WIDTH; cnt = 1; res_ovf = 0;
  - next state = HOLD if len_q==1, else ACC.
- ACC, prod_valid=1:
  - acc = sat(acc + sext(prod)); cnt = cnt+1;
  - if cnt+1 == len_q, next state = HOLD.
  - Cycles without prod_valid hold all state; gaps between terms are unbounded.
- Saturating add:
  - compute the sum in ACC_WIDTH+1 bits;
  - if the top two bits differ, clamp to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) according to bit ACC_WIDTH, and set res_ovf=1;
  - accumulation continues from the clamped value; res_ovf stays set until the result is consumed or cleared.
  - The first term never overflows because ACC_WIDTH >= 2*WIDTH.
- Latency: res_valid rises on the clock edge after the final term's prod_valid edge. res, res_ovf are stable while res_valid=1 and res_ready=0.
- HOLD, res_ready=1, prod_valid=0: next state = IDLE; acc=0; res_ovf=0.
- HOLD, res_ready=1, prod_valid=1 (same cycle): result is consumed AND the product starts a new block exactly as in IDLE (len sampled now). No bubble, no drop.
- HOLD, res_ready=0, prod_valid=1: product is discarded; drop=1 for one cycle; res unchanged.
- acc_clr=1 (below rst, above everything else):
  - next state = IDLE; acc=0; cnt=0; res_ovf=0; res_valid drops next cycle;
  - a prod_valid in the same cycle is ignored and drop is not asserted.
- cnt never wraps, because a block ends when cnt reaches len_q <= 2^CNT_WIDTH-1.
- len changes after the first term have no effect on the current block.

Test Plan:
- Reset: rst=1 for 2 cycles with random prod/prod_valid -> res=0, res_valid=0, busy=0, res_ovf=0, drop=0.
- len=3; prod = 8'h06, 8'hF6 (-10), 8'h14 (20) on consecutive cycles; res_ready=0 -> next cycle res=16'h0010, res_valid=1, res_ovf=0; values stable for 5 cycles; res_ready=1 -> res_valid=0, busy=0 next cycle.
- len=0 (treated as 1), prod=8'hC8 (-56) -> next cycle res=16'hFFC8, res_valid=1.
- ACC_WIDTH=8, len=4; prods 64, 64, -8, -8 -> acc 64, 127 (saturated), 119, 111; final res=8'h6F, res_ovf=1; after consumption the next block has res_ovf=0.
- In HOLD with res_ready=0, prod_valid with prod=5 -> drop=1 for one cycle, res unchanged. Then res_ready=1 with prod_valid, prod=5, len=1 in the same cycle -> one handshake, next cycle res=5, res_valid=1, drop=0.
- len=3, two terms (3, 4) accepted, then acc_clr=1 with prod_valid=1 -> next cycle busy=0, res=0, drop=0. New block len=2 with 3, 4 -> res=7.
